// File: rtl/i2c_types_pkg.sv
// Shared types for the I2C target: FSM state encoding and the ACK/NACK bus levels.
package i2c_types_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_LOAD,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_slv_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Bus lines plus the byte-level write/read handshake between the I2C target and its user logic.
interface i2c_slave_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  scl_i;
    logic                  sda_i;
    logic                  scl_o;
    logic                  sda_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  wr_valid_o;
    logic                  wr_ready_i;
    logic                  rd_req_o;
    logic [DATA_WIDTH-1:0] rd_data_i;
    logic                  rd_valid_i;
    logic                  busy_o;
    logic                  stop_o;
    logic                  rd_underrun_o;

    modport slave (
        input  scl_i, sda_i, wr_ready_i, rd_data_i, rd_valid_i,
        output scl_o, sda_o, wr_data_o, wr_valid_o, rd_req_o, busy_o, stop_o, rd_underrun_o
    );

    modport master (
        output scl_i, sda_i, wr_ready_i, rd_data_i, rd_valid_i,
        input  scl_o, sda_o, wr_data_o, wr_valid_o, rd_req_o, busy_o, stop_o, rd_underrun_o
    );

endinterface

// File: rtl/i2c_slv_sync_edge.sv
// Multi-flop synchronizer for one bus line followed by an edge-detect flop.
module i2c_slv_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Lines idle high, so reset to 1 to avoid a spurious edge when reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: START/STOP detect, 7-bit address match, byte write/read over valid/ready.
// Define I2C_CLK_STRETCH_EN to hold SCL low while waiting for read data instead of sending 0xFF.
module i2c_slave_responder
    import i2c_types_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                        SYNC_STAGES    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    i2c_slave_responder_if.slave  bus
);

`ifdef I2C_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    localparam int         W        = I2C_DATA_WIDTH;
    localparam logic [3:0] LAST_BIT = 4'(I2C_DATA_WIDTH);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_slv_state_t state;
    logic [W-1:0]   shift_reg;
    logic [3:0]     bit_cnt;
    logic           scl_q, sda_q;
    logic [W-1:0]   wr_data_q;
    logic           wr_valid_q, rd_req_q, busy_q, stop_q, underrun_q;

    i2c_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk_i), .rst_n(rst_i), .line(bus.scl_i),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk_i), .rst_n(rst_i), .line(bus.sda_i),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    // Using the post-edge SCL level means an SCL edge in the same clk is applied first.
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            stop_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere; the pulse defaults below are overridden later in this block.
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            stop_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (stop_det) begin
                state   <= IDLE;
                stop_q  <= busy_q;
                busy_q  <= 1'b0;
                bit_cnt <= '0;
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
            end else if (start_det) begin
                state   <= ADDR;
                busy_q  <= 1'b0;
                bit_cnt <= '0;
                scl_q   <= 1'b1;
                sda_q   <= 1'b1;
            end else begin
                case (state)
                    IDLE, IGNORE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[W-2:0], sda_lvl};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (shift_reg[W-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                                sda_q  <= I2C_ACK;
                                busy_q <= 1'b1;
                                state  <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_q <= 1'b1;
                            if (shift_reg[0]) begin
                                rd_req_q <= 1'b1;
                                scl_q    <= !STRETCH;
                                state    <= RD_LOAD;
                            end else begin
                                state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[W-2:0], sda_lvl};
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == LAST_BIT - 4'd1) begin
                                wr_data_q  <= {shift_reg[W-2:0], sda_lvl};
                                wr_valid_q <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            sda_q   <= bus.wr_ready_i ? I2C_ACK : I2C_NACK;
                            state   <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        // The level driven during the ACK slot records whether the byte was accepted.
                        if (scl_fall) begin
                            sda_q <= 1'b1;
                            state <= (sda_q == I2C_ACK) ? WR_DATA : IGNORE;
                        end
                    end
                    RD_LOAD: begin
                        // Without stretching, a rise here means the MSB slot has already gone out as 1.
                        if (!STRETCH && scl_rise) begin
                            bit_cnt <= 4'd1;
                        end else if (!STRETCH && scl_fall && bit_cnt != 4'd0) begin
                            shift_reg  <= '1;
                            sda_q      <= 1'b1;
                            underrun_q <= 1'b1;
                            state      <= RD_DATA;
                        end else if (bus.rd_valid_i && bit_cnt == 4'd0) begin
                            shift_reg <= bus.rd_data_i;
                            sda_q     <= bus.rd_data_i[W-1];
                            state     <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        scl_q <= 1'b1;
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                sda_q   <= 1'b1;
                                state   <= RD_ACK;
                            end else begin
                                shift_reg <= {shift_reg[W-2:0], 1'b1};
                                sda_q     <= shift_reg[W-2];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[W-2:0], sda_lvl};
                        end else if (scl_fall) begin
                            if (shift_reg[0] == I2C_ACK) begin
                                rd_req_q <= 1'b1;
                                scl_q    <= !STRETCH;
                                bit_cnt  <= '0;
                                state    <= RD_LOAD;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.scl_o         = scl_q;
    assign bus.sda_o         = sda_q;
    assign bus.wr_data_o     = wr_data_q;
    assign bus.wr_valid_o    = wr_valid_q;
    assign bus.rd_req_o      = rd_req_q;
    assign bus.busy_o        = busy_q;
    assign bus.stop_o        = stop_q;
    assign bus.rd_underrun_o = underrun_q;

endmodule
